// File: rtl/mul_seq_ctrl.sv
// Sequential 32-bit multiplier controller. The multiplier operand is consumed one
// 5-bit digit per cycle, through a single 32x5 shift-add multiplier.

module mul_shift5 (
  input  logic [31:0] a,
  input  logic [4:0]  b,
  output logic [31:0] p
);

  always_comb begin
    p = '0;
    for (int i = 0; i < 5; i++) begin
      if (b[i]) begin
        p = p + (a << i);
      end
    end
  end

endmodule

module mul_seq_ctrl #(
  parameter int NUM_DIGITS = 4
) (
  input  logic                    I_CLK,
  input  logic                    I_RST,
  input  logic                    I_VALID,
  output logic                    O_READY,
  input  logic [31:0]             I_A,
  input  logic [5*NUM_DIGITS-1:0] I_B,
  output logic                    O_VALID,
  input  logic                    I_READY,
  output logic [31:0]             O_PROD,
  output logic                    O_BUSY
);

  localparam int BW = 5 * NUM_DIGITS;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [31:0]     a_reg;
  logic [BW-1:0]   b_reg;
  logic [BW-1:0]   b_shifted;
  logic [31:0]     acc;
  logic [31:0]     acc_next;
  logic [31:0]     mul_out;
  logic [2:0]      k;
  logic [4:0]      shamt;
  logic            last_digit;

  mul_shift5 u_mul (
    .a (a_reg),
    .b (b_reg[4:0]),
    .p (mul_out)
  );

  // Digit weight 5*k is built from shifts and an add so no second multiplier appears.
  assign shamt      = {k, 2'b00} + {2'b00, k};
  assign acc_next   = acc + (mul_out << shamt);
  assign b_shifted  = b_reg >> 5;
  assign last_digit = (k == 3'(NUM_DIGITS - 1)) || (b_shifted == '0);

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    O_READY    = 1'b0;
    O_BUSY     = 1'b0;
    O_VALID    = 1'b0;
    case (state)
      IDLE: begin
        O_READY = 1'b1;
        if (I_VALID) begin
          state_next = RUN;
        end
      end
      RUN: begin
        O_BUSY = 1'b1;
        if (last_digit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        O_VALID = 1'b1;
        if (I_READY) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // O_PROD is loaded only when a result completes, so it holds through IDLE and
  // does not follow the accumulator being cleared by the next request.
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      a_reg  <= '0;
      b_reg  <= '0;
      acc    <= '0;
      k      <= '0;
      O_PROD <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (I_VALID) begin
            a_reg <= I_A;
            b_reg <= I_B;
            acc   <= '0;
            k     <= '0;
          end
        end
        RUN: begin
          acc   <= acc_next;
          b_reg <= b_shifted;
          k     <= k + 3'd1;
          if (last_digit) begin
            O_PROD <= acc_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl: products, latency, DONE hold-off, and reset
// while an operation is in flight.

module tb_mul_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] a;
  logic [19:0] b;
  logic        out_valid;
  logic        in_ready;
  logic [31:0] prod;
  logic        busy;

  int checks;
  int passes;

  mul_seq_ctrl #(.NUM_DIGITS(4)) dut (
    .I_CLK   (clk),
    .I_RST   (rst),
    .I_VALID (in_valid),
    .O_READY (out_ready),
    .I_A     (a),
    .I_B     (b),
    .O_VALID (out_valid),
    .I_READY (in_ready),
    .O_PROD  (prod),
    .O_BUSY  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issues one request and waits for the result; latency and busy cycles must be h+1.
  task automatic applyStimulus(input string tag, input logic [31:0] av, input logic [19:0] bv,
                               input logic [31:0] exp_prod, input int h);
    int edges;
    int busy_cycles;
    @(negedge clk);
    checkOutput({tag, "_ready"}, 32'(out_ready), 32'd1);
    a = av;
    b = bv;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    edges = 0;
    busy_cycles = 0;
    while (!out_valid && edges < 20) begin
      if (busy) busy_cycles++;
      @(posedge clk);
      #1;
      edges++;
    end
    checkOutput({tag, "_latency"}, 32'(edges), 32'(h + 1));
    checkOutput({tag, "_busy"}, 32'(busy_cycles), 32'(h + 1));
    checkOutput({tag, "_prod"}, prod, exp_prod);
  endtask

  task automatic release_result(input string tag, input logic [31:0] exp_prod);
    @(negedge clk);
    in_ready = 1'b1;
    @(posedge clk);
    #1;
    in_ready = 1'b0;
    checkOutput({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_idle_ready"}, 32'(out_ready), 32'd1);
    checkOutput({tag, "_prod_kept"}, prod, exp_prod);
  endtask

  initial begin
    checks   = 0;
    passes   = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_ready = 1'b0;
    a        = '0;
    b        = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_ready", 32'(out_ready), 32'd1);
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_prod", prod, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus("small", 32'd3, 20'd5, 32'd15, 0);
    release_result("small", 32'd15);

    applyStimulus("full", 32'hFFFF_FFFF, 20'hFFFFF, 32'hFFF0_0001, 3);
    release_result("full", 32'hFFF0_0001);

    applyStimulus("digit1", 32'd7, 20'h00020, 32'h0000_00E0, 1);
    release_result("digit1", 32'h0000_00E0);

    applyStimulus("zero_b", 32'h1234_5678, 20'h00000, 32'd0, 0);
    release_result("zero_b", 32'd0);

    applyStimulus("spread", 32'h1234_5678, 20'h08421, 32'h5555_0578, 3);
    release_result("spread", 32'h5555_0578);

    // Result held in DONE while a stray request is pulsed; it must not be queued.
    applyStimulus("hold", 32'd3, 20'd5, 32'd15, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = (i == 1);
      a = 32'd100;
      b = 20'd7;
      @(posedge clk);
      #1;
      checkOutput("hold_prod", prod, 32'd15);
      checkOutput("hold_valid", 32'(out_valid), 32'd1);
      checkOutput("hold_ready", 32'(out_ready), 32'd0);
    end
    in_valid = 1'b0;
    release_result("hold", 32'd15);
    @(posedge clk);
    #1;
    checkOutput("hold_no_queue", 32'(busy), 32'd0);

    // Reset during the second RUN cycle discards the operation.
    @(negedge clk);
    a = 32'hFFFF_FFFF;
    b = 20'hFFFFF;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    in_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_ready = 1'b0;
    checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_ready", 32'(out_ready), 32'd1);
    checkOutput("mid_rst_prod", prod, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkOutput("mid_rst_no_valid", 32'(out_valid), 32'd0);
    end

    applyStimulus("after_rst", 32'd2, 20'd9, 32'd18, 0);
    release_result("after_rst", 32'd18);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running, expected finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule

// File: doc/mul_seq_ctrl.md
MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

Interface
REQ-001 Parameter: NUM_DIGITS, default 4, number of 5-bit multiplier digits in I_B; legal range 1..6.
REQ-002 Port: I_CLK  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: I_RST  input  1  synchronous, active-high reset; sampled on the I_CLK rising edge.
REQ-004 Port: I_VALID  input  1  request valid; I_A and I_B are qualified by it.
REQ-005 Port: O_READY  output  1  block can accept a request this cycle.
REQ-006 Port: I_A  input  32  multiplicand.
REQ-007 Port: I_B  input  5*NUM_DIGITS  multiplier, unsigned.
REQ-008 Port: O_VALID  output  1  O_PROD holds a completed result.
REQ-009 Port: I_READY  input  1  consumer accepts the result.
REQ-010 Port: O_PROD  output  32  product (I_A*I_B) mod 2^32.
REQ-011 Port: O_BUSY  output  1  high while in RUN.

Function
REQ-012 The block SHALL instantiate exactly one mul_shift5 (32-bit x 5-bit shift-add, 32-bit truncated result) and SHALL use no other multiplier.
REQ-013 FSM states SHALL be IDLE, RUN and DONE. O_READY=1 only in IDLE, O_BUSY=1 only in RUN, O_VALID=1 only in DONE.
REQ-014 IDLE->RUN SHALL occur on an edge with I_VALID=1 in IDLE; that edge latches I_A into reg A, I_B into reg B, clears the accumulator and sets digit index k=0.
REQ-015 I_VALID in RUN or DONE SHALL be ignored; no request is queued.
REQ-016 Each RUN cycle SHALL feed A and B[4:0] to mul_shift5 and update acc <= acc + (mul_out << 5k), both truncated to 32 bits; B <= B >> 5; k <= k+1.
REQ-017 RUN->DONE SHALL occur on the edge that processes digit k when k==NUM_DIGITS-1 or the post-shift B is zero (zero-digit skip); otherwise RUN is held.
REQ-018 Latency: with accept on edge t and h = index of the highest nonzero digit of I_B (h=0 if I_B=0), O_VALID SHALL first be high in the cycle after edge t+h+1.
REQ-019 O_PROD SHALL equal the final acc, and O_PROD and O_VALID SHALL remain stable in DONE until an edge with I_READY=1.
REQ-020 DONE->IDLE SHALL occur on an edge with I_READY=1; O_VALID drops in the next cycle, and O_PROD retains its last value.
REQ-021 The earliest next accept SHALL be the edge after DONE->IDLE; the minimum request spacing is h+3 cycles.
REQ-022 Arithmetic SHALL be unsigned, with all overflow beyond bit 31 discarded silently.

Reset
REQ-023 While I_RST=1 at an edge: state SHALL go to IDLE; O_VALID=0, O_BUSY=0 and O_READY=1 from the next cycle; O_PROD, acc, A, B and k SHALL be cleared to 0.
REQ-024 Reset asserted in RUN or DONE SHALL discard the operation in flight, and no O_VALID SHALL follow for it.
REQ-025 I_RST SHALL take priority over I_VALID and I_READY on the same edge.

Verification
REQ-026 The bench SHALL cover: A=3, B=5, NUM_DIGITS=4 -> O_PROD=15, O_VALID 2 cycles after accept (h=0).
REQ-027 The bench SHALL cover: A=0xFFFFFFFF, B=0xFFFFF -> O_PROD=0xFFF00001, O_VALID 5 cycles after accept, O_BUSY high for 4 cycles.
REQ-028 The bench SHALL cover: A=7, B=0x00020 -> O_PROD=0xE0 after 3 cycles; then A=0x12345678, B=0 -> O_PROD=0 after 2 cycles.
REQ-029 The bench SHALL cover: I_READY held 0 for 3 cycles in DONE with I_VALID=1 pulsed -> O_PROD stable, O_READY=0, the request ignored; I_READY=1 -> IDLE next cycle.
REQ-030 The bench SHALL cover: I_RST=1 in the second RUN cycle -> next cycle O_VALID=0, O_BUSY=0, O_READY=1, O_PROD=0; a following request A=2, B=9 -> O_PROD=18.
